extender: RTL and testbench

EXTENDER -- requirements
Module: Extender

---
 rtl/extender_pkg.sv | 23 ++
 rtl/extender_imm_decoder.sv | 45 ++++
 rtl/extender.sv | 70 +++++++
 tb/tb_extender.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/extender_pkg.sv
// -----------------------------------------------------------------------------
// extender_pkg
// Shared parameters for the immediate extender: default datapath width, the
// decoded instruction width and the immediate-format select encodings.
// Consumers: extender, extender_imm_decoder and the bench.
// -----------------------------------------------------------------------------
package extender_pkg;

   // Default datapath width; 32 and 64 are the supported values.
   localparam int XLEN_DEFAULT = 32;

   // Only the low 32 bits of an instruction word carry encoding information.
   localparam int INSTR_W = 32;

   // Immediate format select encodings.
   typedef enum logic [1:0] {
      I_TYPE_IMM = 2'b00,
      S_TYPE_IMM = 2'b01,
      B_TYPE_IMM = 2'b10,
      U_TYPE_IMM = 2'b11
   } imm_type_e;

endpackage : extender_pkg

// File: rtl/extender_imm_decoder.sv
// -----------------------------------------------------------------------------
// extender_imm_decoder
// Selects the immediate field of a 32-bit instruction according to the format
// select and sign-extends it to XLEN bits. Purely combinational.
// Ports:
//   instr    in  [31:0]      instruction bits to decode
//   imm_type in  [1:0]       immediate format select (imm_type_e)
//   ext_imm  out [XLEN-1:0]  sign-extended immediate
// -----------------------------------------------------------------------------
module extender_imm_decoder
   import extender_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [1:0]         imm_type,
   output logic [XLEN-1:0]    ext_imm
);

   logic [INSTR_W-1:0] imm32_s;
   // The opcode field never contributes to an immediate.
   logic [6:0]         unused_opcode_s;

   assign unused_opcode_s = instr[6:0];

   // Assemble the 32-bit immediate for the selected format.
   always_comb begin
      imm32_s = 32'h0000_0000;
      case (imm_type_e'(imm_type))
         I_TYPE_IMM: imm32_s = {{20{instr[31]}}, instr[31:20]};
         S_TYPE_IMM: imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         B_TYPE_IMM: imm32_s = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
         U_TYPE_IMM: imm32_s = {instr[31:12], 12'h000};
         default:    imm32_s = 32'h0000_0000;
      endcase
   end

   // Replicate the instruction sign bit above bit 31 (no-op when XLEN is 32).
   always_comb begin
      ext_imm        = {XLEN{instr[31]}};
      ext_imm[31:0]  = imm32_s;
   end

endmodule : extender_imm_decoder

// File: rtl/extender.sv
// -----------------------------------------------------------------------------
// extender
// Immediate sign extender: wraps extender_imm_decoder and optionally registers
// its result.
// Configuration macro: EXTENDER_REG_OUT_EN
//   defined   -> extendedImmQ is a flop loaded every rising clk edge, cleared
//                asynchronously while rst is high.
//   undefined -> extendedImmQ mirrors extendedImm; no flops, clk/rst unused.
// Ports:
//   clk          in  1         clock (registered build only)
//   rst          in  1         asynchronous active-high reset
//   instruction  in  XLEN      instruction word; only bits [31:0] decoded
//   immType      in  2         immediate format select (imm_type_e)
//   extendedImm  out XLEN      combinational sign-extended immediate
//   extendedImmQ out XLEN      registered (or mirrored) copy of extendedImm
// -----------------------------------------------------------------------------
module extender
   import extender_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] instruction,
   input  logic [1:0]      immType,
   output logic [XLEN-1:0] extendedImm,
   output logic [XLEN-1:0] extendedImmQ
);

   // On a 64-bit datapath the upper instruction half is deliberately ignored.
   logic [XLEN-1:0] unused_instruction_s;

   assign unused_instruction_s = instruction;

   extender_imm_decoder #(
      .XLEN     (XLEN)
   ) u_imm_decoder (
      .instr    (instruction[INSTR_W-1:0]),
      .imm_type (immType),
      .ext_imm  (extendedImm)
   );

`ifdef EXTENDER_REG_OUT_EN
   logic [XLEN-1:0] extended_imm_d;
   logic [XLEN-1:0] extended_imm_q;

   // Next value of the output register is always the current immediate.
   always_comb begin
      extended_imm_d = extendedImm;
   end

   // Output register, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         extended_imm_q <= {XLEN{1'b0}};
      end else begin
         extended_imm_q <= extended_imm_d;
      end
   end

   assign extendedImmQ = extended_imm_q;
`else
   // Without the register option the clock and reset have no loads.
   logic [1:0] unused_clk_rst_s;

   assign unused_clk_rst_s = {clk, rst};
   assign extendedImmQ     = extendedImm;
`endif

endmodule : extender

// File: tb/tb_extender.sv
// -----------------------------------------------------------------------------
// tb_extender
// Self-checking bench for extender (XLEN=32 and XLEN=64 instances). Expected
// immediates come from an arithmetic model of the immediate formats; the
// register-option behaviour follows EXTENDER_REG_OUT_EN.
// -----------------------------------------------------------------------------
module tb_extender;

   logic        clk;
   logic        rst;
   logic [31:0] instr32;
   logic [63:0] instr64;
   logic [1:0]  imm_type;
   logic [31:0] ext32;
   logic [31:0] ext32_q;
   logic [63:0] ext64;
   logic [63:0] ext64_q;

   int n_cmp  = 0;
   int n_fail = 0;

   extender #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .instruction  (instr32),
      .immType      (imm_type),
      .extendedImm  (ext32),
      .extendedImmQ (ext32_q)
   );

   extender #(.XLEN(64)) dut64 (
      .clk          (clk),
      .rst          (rst),
      .instruction  (instr64),
      .immType      (imm_type),
      .extendedImm  (ext64),
      .extendedImmQ (ext64_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: immediate value built with shifts on a signed word, then
   // sign-extended to 64 bits.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [1:0] t);
      logic signed [31:0] s;
      logic [31:0]        r;
      s = $signed(ins);
      case (t)
         2'd0:    r = 32'(s >>> 20);
         2'd1:    r = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
         2'd2:    r = (32'(s >>> 31) << 12) | (32'(ins[7]) << 11)
                      | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         default: r = ins & 32'hFFFF_F000;
      endcase
      return {{32{r[31]}}, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one vector at the falling edge, check the combinational outputs,
   // then check the copies after the next rising edge.
   task automatic step(input logic [31:0] ins, input logic [1:0] t,
                       input logic [31:0] hi, input string tag);
      logic [63:0] e;
      @(negedge clk);
      instr32  = ins;
      instr64  = {hi, ins};
      imm_type = t;
      e = ref_imm(ins, t);
      #1;
      check({tag, "_comb32"}, {32'h0, ext32}, {32'h0, e[31:0]});
      check({tag, "_comb64"}, ext64, e);
      @(posedge clk);
      #1;
      check({tag, "_q32"}, {32'h0, ext32_q}, {32'h0, e[31:0]});
      check({tag, "_q64"}, ext64_q, e);
   endtask

   initial begin
      rst      = 1'b1;
      instr32  = 32'h0000_0000;
      instr64  = 64'h0;
      imm_type = 2'b00;

      // Reset phase: combinational path unaffected, registered copy cleared.
      #2;
      instr32 = 32'hA549_9303;
      instr64 = {32'hDEAD_BEEF, 32'hA549_9303};
      #1;
      check("rst_comb32", {32'h0, ext32}, 64'h0000_0000_FFFF_FA54);
      check("rst_comb64", ext64, 64'hFFFF_FFFF_FFFF_FA54);
`ifdef EXTENDER_REG_OUT_EN
      check("rst_q32", {32'h0, ext32_q}, 64'h0);
      @(posedge clk);
      #1;
      check("rst_q32_after_edge", {32'h0, ext32_q}, 64'h0);
      check("rst_q64_after_edge", ext64_q, 64'h0);
`else
      check("rst_q32", {32'h0, ext32_q}, 64'h0000_0000_FFFF_FA54);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with literal expectations.
      step(32'h0004_9403, 2'b00, 32'h0, "i_zero");
      check("i_zero_lit", {32'h0, ext32}, 64'h0);
      step(32'hA549_9303, 2'b00, 32'h0, "i_neg");
      check("i_neg_lit", {32'h0, ext32}, 64'h0000_0000_FFFF_FA54);
      check("i_neg_q_lit", {32'h0, ext32_q}, 64'h0000_0000_FFFF_FA54);
      step(32'hFFF4_9303, 2'b00, 32'h1234_5678, "i_m1");
      check("i_m1_lit", {32'h0, ext32}, 64'h0000_0000_FFFF_FFFF);
      check("x64_i_m1_lit", ext64, 64'hFFFF_FFFF_FFFF_FFFF);
      step(32'hFE11_2E23, 2'b01, 32'h0, "s_neg");
      check("s_neg_lit", {32'h0, ext32}, 64'h0000_0000_FFFF_FFFC);
      step(32'hFE00_0EE3, 2'b10, 32'h0, "b_neg");
      check("b_neg_lit", {32'h0, ext32}, 64'h0000_0000_FFFF_FFFC);
      step(32'h1234_50B7, 2'b11, 32'hFFFF_FFFF, "u_pos");
      check("u_pos_lit", {32'h0, ext32}, 64'h0000_0000_1234_5000);
      check("x64_u_pos_lit", ext64, 64'h0000_0000_1234_5000);
      step(32'h7FFF_FFFF, 2'b10, 32'h0, "b_posmax");
      step(32'h8000_0000, 2'b01, 32'h0, "s_signonly");

      // Mid-stream reset: output copy clears without a clock edge.
      step(32'hA549_9303, 2'b00, 32'h0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_comb32", {32'h0, ext32}, 64'h0000_0000_FFFF_FA54);
`ifdef EXTENDER_REG_OUT_EN
      check("mid_rst_q32", {32'h0, ext32_q}, 64'h0);
      check("mid_rst_q64", ext64_q, 64'h0);
`else
      check("mid_rst_q32", {32'h0, ext32_q}, 64'h0000_0000_FFFF_FA54);
      check("mid_rst_q64", ext64_q, 64'hFFFF_FFFF_FFFF_FA54);
`endif
      @(negedge clk);
      rst = 1'b0;
      step(32'hA549_9303, 2'b00, 32'h0, "post_rst");

      // Random vectors across all formats and random upper instruction bits.
      for (int i = 0; i < 150; i++) begin
         step($urandom, 2'($urandom_range(0, 3)), $urandom, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_extender
